// File: rtl/gray_seq_ctrl.sv
// Gray-coded run controller. A prescaler paces steps of a binary count in ONCE, WRAP and PINGPONG modes.
// gray_out is decoded combinationally from the count register.
module gray_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             halt,
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             dir,
  output logic             wrap,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_WRAP = 2'b10;
  localparam logic [1:0] OP_PP   = 2'b11;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic [DIV_W-1:0] pre_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       op_q;
  logic             wrap_q;
  logic             tick;

  assign tick = (pre_q == div_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      pre_q   <= '0;
      div_q   <= '0;
      op_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && (cmd_op != OP_NOP)) begin
            op_q    <= cmd_op;
            limit_q <= cmd_limit;
            div_q   <= cmd_div;
            count_q <= '0;
            pre_q   <= '0;
            state_q <= UP;
          end
        end
        UP, DOWN: begin
          // halt wins over a coincident tick; count and prescaler are frozen
          if (halt) begin
            state_q <= IDLE;
          end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
              if (state_q == UP) begin
                if (count_q != limit_q) begin
                  count_q <= count_q + 1'b1;
                end else begin
                  case (op_q)
                    OP_WRAP: begin
                      count_q <= '0;
                      wrap_q  <= 1'b1;
                    end
                    OP_PP: begin
                      state_q <= DOWN;
                      count_q <= (limit_q == '0) ? '0 : limit_q - 1'b1;
                    end
                    default: state_q <= DONE;
                  endcase
                end
              end else begin
                if (count_q != '0) begin
                  count_q <= count_q - 1'b1;
                end else begin
                  // a zero limit keeps the count parked at 0 while direction toggles
                  state_q <= UP;
                  count_q <= (limit_q == '0) ? '0 : WIDTH'(1);
                end
              end
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign gray_out  = count_q ^ (count_q >> 1);
  assign busy      = (state_q == UP) || (state_q == DOWN);
  assign dir       = (state_q == DOWN);
  assign wrap      = wrap_q;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: table vectors, directed corner sequences and random stimulus
// checked against a behavioural run model.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_limit;
  logic [7:0] cmd_div;
  logic       halt;
  logic [3:0] gray_out;
  logic       busy, dir, wrap, done;

  int checks = 0;
  int errors = 0;

  // behavioural model of a run
  bit m_run, m_down, m_done, m_wrap;
  int m_count, m_pre, m_op, m_limit, m_div;

  gray_seq_ctrl #(.WIDTH(4), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_limit(cmd_limit), .cmd_div(cmd_div), .halt(halt),
    .gray_out(gray_out), .busy(busy), .dir(dir), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] lim;
    logic [7:0] dv;
    logic       h;
    logic [3:0] g;
    logic       b, d, dn, w, r;
  } vec_t;

  vec_t tbl[13];

  function automatic int gray_of(input int c);
    return (c ^ (c >> 1)) & 15;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_outs();
    return {23'd0, gray_out, busy, dir, done, wrap, cmd_ready};
  endfunction

  function automatic int model_outs();
    int g;
    g = gray_of(m_count);
    return (g << 5) | (int'(m_run) << 4) | (int'(m_run && m_down) << 3) |
           (int'(m_done) << 2) | (int'(m_wrap) << 1) | int'(!m_run && !m_done);
  endfunction

  task automatic model_reset();
    m_run = 0; m_down = 0; m_done = 0; m_wrap = 0;
    m_count = 0; m_pre = 0; m_op = 0; m_limit = 0; m_div = 0;
  endtask

  // advance one clock: model computes the next run state from the inputs present before the edge
  task automatic step();
    bit n_run, n_down, n_done, n_wrap;
    int n_count, n_pre, n_op, n_limit, n_div;
    n_run = m_run; n_down = m_down; n_done = 0; n_wrap = 0;
    n_count = m_count; n_pre = m_pre; n_op = m_op; n_limit = m_limit; n_div = m_div;
    if (m_done) begin
      n_done = 0;
    end else if (!m_run) begin
      if (cmd_valid && cmd_op != 0) begin
        n_op = cmd_op; n_limit = cmd_limit; n_div = cmd_div;
        n_count = 0; n_pre = 0; n_run = 1; n_down = 0;
      end
    end else if (halt) begin
      n_run = 0;
    end else if (m_pre == m_div) begin
      n_pre = 0;
      if (!m_down) begin
        if (m_count < m_limit) n_count = m_count + 1;
        else if (m_op == 2) begin n_count = 0; n_wrap = 1; end
        else if (m_op == 3) begin n_down = 1; n_count = (m_limit > 0) ? m_limit - 1 : 0; end
        else begin n_run = 0; n_done = 1; end
      end else begin
        if (m_count > 0) n_count = m_count - 1;
        else begin n_down = 0; n_count = (m_limit > 0) ? 1 : 0; end
      end
    end else begin
      n_pre = m_pre + 1;
    end
    @(posedge clk);
    #1;
    m_run = n_run; m_down = n_down; m_done = n_done; m_wrap = n_wrap;
    m_count = n_count; m_pre = n_pre; m_op = n_op; m_limit = n_limit; m_div = n_div;
    chk("model_outs", dut_outs(), model_outs());
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_op = 0; cmd_limit = 0; cmd_div = 0; halt = 0;
  endtask

  initial begin
    int wp, bz, n;
    bit found;
    int pp_cnt[7];
    int pp_dir[7];
    pp_cnt = '{0, 1, 2, 1, 0, 1, 2};
    pp_dir = '{0, 0, 0, 1, 1, 0, 0};

    //        v  op    lim   dv    h     g     b d dn w r
    tbl[0]  = '{1, 2'd1, 4'd5, 8'd0, 1'b0, 4'd0, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 2'd0, 4'd0, 8'd0, 1'b0, 4'd1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 2'd2, 4'd9, 8'd0, 1'b0, 4'd3, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 2'd0, 4'd0, 8'd0, 1'b0, 4'd2, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 2'd0, 4'd0, 8'd0, 1'b0, 4'd6, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 2'd0, 4'd0, 8'd0, 1'b0, 4'd7, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 2'd0, 4'd0, 8'd0, 1'b0, 4'd7, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 2'd0, 4'd0, 8'd0, 1'b0, 4'd7, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 2'd0, 4'd3, 8'd0, 1'b1, 4'd7, 0, 0, 0, 0, 1};
    tbl[9]  = '{1, 2'd1, 4'd1, 8'd0, 1'b0, 4'd0, 1, 0, 0, 0, 0};
    tbl[10] = '{0, 2'd0, 4'd0, 8'd0, 1'b0, 4'd1, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 2'd0, 4'd0, 8'd0, 1'b0, 4'd1, 0, 0, 1, 0, 0};
    tbl[12] = '{0, 2'd0, 4'd0, 8'd0, 1'b1, 4'd1, 0, 0, 0, 0, 1};

    idle_inputs();
    rst = 1;
    model_reset();
    #1;
    chk("reset_async_outs", dut_outs(), 0);
    @(posedge clk);
    #1;
    chk("reset_outs", dut_outs(), 0);
    rst = 0;
    #1;
    chk("reset_release_ready", int'(cmd_ready), 1);

    // ONCE limit=5 div=0, busy-time command ignored, NOP, reissue, halt ignored in IDLE/DONE
    for (int i = 0; i < 13; i++) begin
      cmd_valid = tbl[i].v; cmd_op = tbl[i].op; cmd_limit = tbl[i].lim;
      cmd_div = tbl[i].dv; halt = tbl[i].h;
      step();
      chk($sformatf("tbl%0d", i), dut_outs(),
          {23'd0, tbl[i].g, tbl[i].b, tbl[i].d, tbl[i].dn, tbl[i].w, tbl[i].r});
    end
    idle_inputs();

    // WRAP limit=3 div=1
    cmd_valid = 1; cmd_op = 2; cmd_limit = 3; cmd_div = 1;
    step();
    idle_inputs();
    wp = 0; bz = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (wrap) wp++;
      if (!busy) bz = 0;
    end
    chk("wrap_pulses", wp, 1);
    chk("wrap_busy", bz, 1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_count == 3 && m_pre == m_div) begin found = 1; break; end
      step();
    end
    chk("halt_setup_found", int'(found), 1);
    halt = 1;
    step();
    halt = 0;
    chk("halt_gray", int'(gray_out), 2);
    chk("halt_ready", int'(cmd_ready), 1);
    chk("halt_nowrap", {30'd0, wrap, busy}, 0);
    step();
    chk("halt_held_gray", int'(gray_out), 2);

    // PINGPONG limit=2 div=0
    cmd_valid = 1; cmd_op = 3; cmd_limit = 2; cmd_div = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      cmd_valid = 0;
      chk($sformatf("pp_gray%0d", i), int'(gray_out), gray_of(pp_cnt[i]));
      chk($sformatf("pp_dir%0d", i), int'(dir), pp_dir[i]);
    end
    for (int i = 0; i < 4; i++) step();
    idle_inputs();

    // PINGPONG limit=0: direction toggles with count pinned at 0
    halt = 1;
    step();
    halt = 0;
    cmd_valid = 1; cmd_op = 3; cmd_limit = 0; cmd_div = 0;
    step();
    cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("pp0_dir%0d", i), int'(dir), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("pp0_gray%0d", i), int'(gray_out), 0);
    end

    // asynchronous reset between edges mid-PINGPONG
    halt = 1;
    step();
    halt = 0;
    cmd_valid = 1; cmd_op = 3; cmd_limit = 5; cmd_div = 0;
    step();
    cmd_valid = 0;
    for (int i = 0; i < 4; i++) step();
    #3;
    rst = 1;
    #1;
    chk("midrun_rst_outs", dut_outs(), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("midrun_rst_hold", dut_outs(), 0);
    rst = 0;
    #1;
    chk("midrun_release_ready", int'(cmd_ready), 1);
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_gray", int'(gray_out), 0);

    // random stimulus against the model, including full-range limit 15
    for (int i = 0; i < 800; i++) begin
      cmd_valid = ($urandom % 3 == 0);
      cmd_op    = 2'($urandom % 4);
      n = $urandom % 4;
      cmd_limit = (n == 0) ? 4'd0 : (n == 1) ? 4'd15 : 4'($urandom % 16);
      cmd_div   = 8'($urandom % 3);
      halt      = ($urandom % 25 == 0);
      step();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
